// File: rtl/range_finder_pio_out_pulse.sv
// ---------------------------------------------------------------------------
// range_finder_pio_out_pulse
//
// Avalon-MM parallel output port with set/clear registers and an optional
// timed-pulse engine. A PULSE write raises a set of output bits for exactly
// PULSE_LEN clock cycles. After that time the engine drops those bits again.
//
// Optional feature macro: PIO_OUT_PULSE_EN
//   defined   : PULSE_LEN / PULSE / STATUS registers and the pulse counter
//               are built.
//   undefined : only DATA / SET / CLEAR exist. Addresses 3-5 read 0 and
//               writes to them are ignored.
//
// Parameters
//   WIDTH        number of output bits (1..32)
//   PULSE_W      width of the pulse-length register and counter (1..32)
//   RESET_VALUE  value loaded into DATA at reset
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   reset        synchronous, active-high reset
//   address[2:0] register word address
//                  0 DATA       (rw)
//                  1 SET        (wo, reads 0)
//                  2 CLEAR      (wo, reads 0)
//                  3 PULSE_LEN  (rw)
//                  4 PULSE      (w: bit mask to pulse, r: active mask)
//                  5 STATUS     (ro, bit0 = busy)
//                  6-7          read 0, writes ignored
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data (bits above the register width are ignored)
//   readdata     combinational read data, zero wait states, zero-extended
//   out_port     output pins, driven straight from DATA
// ---------------------------------------------------------------------------
module range_finder_pio_out_pulse #(
    parameter int               WIDTH       = 8,
    parameter int               PULSE_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLEAR     = 3'd2;
`ifdef PIO_OUT_PULSE_EN
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
    localparam logic [2:0] ADDR_PULSE     = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;
    logic             unused_wdata;

    assign wr_en   = chipselect & ~write_n;
    assign wr_bits = writedata[WIDTH-1:0];

    // Upper writedata bits are deliberately ignored by every register.
    assign unused_wdata = ^writedata;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   data_q,      data_d;
`ifdef PIO_OUT_PULSE_EN
    logic [PULSE_W-1:0] pulse_len_q, pulse_len_d;
    logic [WIDTH-1:0]   mask_q,      mask_d;
    logic [PULSE_W-1:0] count_q,     count_d;
    logic               busy;
    logic               pulse_go;
    logic               expire;

    assign busy = (count_q != '0);

    // A PULSE write is only accepted with a non-empty mask and a nonzero
    // length. Anything else leaves the pulse engine untouched.
    assign pulse_go = wr_en && (address == ADDR_PULSE) &&
                      (wr_bits != '0) && (pulse_len_q != '0);

    // The last active cycle of a pulse. A coincident accepted PULSE write
    // restarts the timer instead, so expiry is suppressed in that case.
    assign expire = (count_q == PULSE_W'(1)) && !pulse_go;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    //
    // The order matters. First the pulse engine runs (restart or
    // countdown/expiry). Then any DATA/SET/CLEAR write is applied on top,
    // so a bus write on the expiry edge wins for the bits it touches.
    // ------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
`ifdef PIO_OUT_PULSE_EN
        pulse_len_d = pulse_len_q;
        mask_d      = mask_q;
        count_d     = count_q;

        if (pulse_go) begin
            // Merging into MASK makes earlier bits ride along to the
            // new expiry time.
            data_d  = data_q | wr_bits;
            mask_d  = mask_q | wr_bits;
            count_d = pulse_len_q;
        end else if (busy) begin
            count_d = count_q - PULSE_W'(1);
            if (expire) begin
                data_d = data_q & ~mask_q;
                mask_d = '0;
            end
        end

        if (wr_en && (address == ADDR_PULSE_LEN)) begin
            pulse_len_d = writedata[PULSE_W-1:0];
        end
`endif

        // These writes never touch MASK/COUNT. A pulsed bit that is
        // cleared early therefore still expires silently later.
        if (wr_en) begin
            case (address)
                ADDR_DATA:  data_d = wr_bits;
                ADDR_SET:   data_d = data_d | wr_bits;
                ADDR_CLEAR: data_d = data_d & ~wr_bits;
                default:    ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers: reset overrides any coincident write and aborts a pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q      <= RESET_VALUE;
`ifdef PIO_OUT_PULSE_EN
            pulse_len_q <= '0;
            mask_q      <= '0;
            count_q     <= '0;
`endif
        end else begin
            data_q      <= data_d;
`ifdef PIO_OUT_PULSE_EN
            pulse_len_q <= pulse_len_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Read mux. The mux is combinational and zero-extended. Write-only
    // and unmapped addresses return 0.
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata[WIDTH-1:0]   = data_q;
`ifdef PIO_OUT_PULSE_EN
            ADDR_PULSE_LEN: readdata[PULSE_W-1:0] = pulse_len_q;
            ADDR_PULSE:     readdata[WIDTH-1:0]   = mask_q;
            ADDR_STATUS:    readdata[0]           = busy;
`endif
            default:        readdata              = '0;
        endcase
    end

    assign out_port = data_q;

endmodule

// File: doc/range_finder_pio_out_pulse.md
RANGE_FINDER_PIO_OUT_PULSE -- requirements
Module: range_finder_pio_out_pulse

Interface
REQ-001 Parameter WIDTH, default 8: number of output bits, legal range 1..32.
REQ-002 Parameter PULSE_W, default 16: width of the pulse-length register and counter, legal range 1..32.
REQ-003 Parameter RESET_VALUE, default 0: WIDTH-bit value loaded into DATA at reset.
REQ-004 Port clk  in  1: single clock; all state changes on its rising edge.
REQ-005 Port reset  in  1: synchronous, active-high reset.
REQ-006 Port address  in  3: Avalon-MM register word address.
REQ-007 Port chipselect  in  1: slave select.
REQ-008 Port write_n  in  1: active-low write strobe.
REQ-009 Port writedata  in  32: write data.
REQ-010 Port readdata  out  32: combinational read data; zero wait states.
REQ-011 Port out_port  out  WIDTH: output pins, driven directly from DATA.

Function
REQ-012 A write SHALL occur only when chipselect=1 and write_n=0 in the same cycle; it takes effect at that clock edge.
REQ-013 Register map: 0 DATA (rw), 1 SET (wo), 2 CLEAR (wo), 3 PULSE_LEN (rw), 4 PULSE (w, r=active mask), 5 STATUS (ro, bit0=busy); addresses 6-7 read 0 and ignore writes.
REQ-014 DATA write: DATA <= writedata[WIDTH-1:0]; bits above WIDTH are ignored.
REQ-015 SET write: DATA <= DATA | writedata[WIDTH-1:0]. CLEAR write: DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-016 Reads of SET and CLEAR SHALL return 0. All reads zero-extend to 32 bits.
REQ-017 out_port SHALL equal DATA, so an output reflects a write in the cycle after the write edge.
REQ-018 PULSE_LEN write: PULSE_LEN <= writedata[PULSE_W-1:0].
REQ-019 A PULSE write with nonzero mask M and PULSE_LEN=N>0 SHALL set DATA |= M, set MASK |= M, and load COUNT <= N.
REQ-020 While COUNT>0, COUNT SHALL decrement by 1 each cycle. On the edge where COUNT=1, DATA &= ~MASK, MASK <= 0, and COUNT <= 0, so the bits stay high for exactly N cycles.
REQ-021 A PULSE write with PULSE_LEN=0 or M=0 SHALL be ignored entirely.
REQ-022 A PULSE write while busy SHALL restart COUNT at PULSE_LEN and merge the new bits into MASK; the earlier bits extend to the new expiry.
REQ-023 busy = (COUNT != 0).
REQ-024 When expiry and a DATA, SET or CLEAR write fall on the same edge, expiry is applied first and the bus write last; the bus write wins for the bits it touches.
REQ-025 When expiry and a PULSE write fall on the same edge, REQ-022 applies and no expiry occurs.
REQ-026 DATA, SET and CLEAR writes SHALL NOT alter MASK or COUNT; a pulsed bit cleared early still expires silently.

Reset
REQ-027 While reset=1 at a clock edge: DATA <= RESET_VALUE, PULSE_LEN <= 0, MASK <= 0, COUNT <= 0.
REQ-028 Reset SHALL override any coincident write and abort a pulse in progress; out_port equals RESET_VALUE from the next cycle.

Configuration
REQ-029 Macro PIO_OUT_PULSE_EN defined: the pulse logic of REQ-018..REQ-026 is built.
REQ-030 Macro PIO_OUT_PULSE_EN undefined: no PULSE_LEN, MASK or COUNT registers exist; addresses 3-5 read 0 and ignore writes; DATA, SET and CLEAR behave identically to the built-in case.

Verification
REQ-031 Reset, then write DATA=0xA5 -> out_port=0x00 before the write and 0xA5 one cycle after; read address 0 returns 0x000000A5.
REQ-032 DATA=0x0F, SET 0x30, then CLEAR 0x03 -> out_port reads 0x3F, then 0x3C; SET and CLEAR read back 0.
REQ-033 PULSE_LEN=4, PULSE 0x80 at edge T -> bit7 high for edges T+1..T+4 and low after T+4; STATUS reads 1 during the pulse and 0 after.
REQ-034 PULSE_LEN=3, PULSE 0x01 at T, PULSE 0x02 at T+2 -> both bits fall together 3 cycles after T+2; PULSE_LEN=0 followed by a PULSE write -> no change.
REQ-035 Expiry edge coincides with DATA write 0xFF -> out_port=0xFF; assert reset during a pulse -> out_port=RESET_VALUE and STATUS=0 the next cycle.
REQ-036 With PIO_OUT_PULSE_EN undefined, write 0x55 to address 4 -> out_port unchanged and addresses 3-5 read 0.
